// File: rtl/cnn_frame_streamer.sv
// cnn_frame_streamer
//   Host-side transmitter for the cnn pixel stream. The host fills a local
//   IMG_WIDTH x IMG_WIDTH frame buffer. A start pulse streams that frame into
//   the cnn at one pixel per cycle. The block then waits for the cnn result,
//   latches the class, and idles for a flush gap before it accepts the next frame.
//   Optional feature macro: CNN_STREAM_TIMEOUT_EN enables the WAIT_RES timeout
//   counter and the timeout_err pulse. When the macro is undefined, WAIT_RES
//   waits forever and timeout_err is tied to 0.
module cnn_frame_streamer #(
  parameter int DATA_WIDTH     = 8,
  parameter int IMG_WIDTH      = 28,
  parameter int ADDR_WIDTH     = 10,
  parameter int GAP_CYCLES     = 30,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  class_valid,
  output logic [3:0]            class_result,
  output logic                  timeout_err,
  output logic                  cnn_valid_in,
  output logic [DATA_WIDTH-1:0] cnn_pixel_in,
  input  logic                  cnn_valid_out,
  input  logic [3:0]            cnn_class_out
);

  localparam int IMG_PIXELS = IMG_WIDTH * IMG_WIDTH;
  localparam int CNT_W      = ADDR_WIDTH + 1;
  localparam int GAP_W      = $clog2(GAP_CYCLES + 1) + 1;

  // Elaboration-time sanity checks on the parameter set
  if ((2 ** ADDR_WIDTH) < IMG_PIXELS) begin : g_addr_check
    $error("cnn_frame_streamer: ADDR_WIDTH too small for IMG_PIXELS");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
    $error("cnn_frame_streamer: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_STREAM   = 2'd1,
    S_WAIT_RES = 2'd2,
    S_GAP      = 2'd3
  } state_t;

  state_t                r_state, w_state;
  logic [CNT_W-1:0]      r_pix_cnt, w_pix_cnt;
  logic [GAP_W-1:0]      r_gap_cnt, w_gap_cnt;
  logic                  r_busy, w_busy;
  logic                  r_done, w_done;
  logic                  r_class_valid, w_class_valid;
  logic [3:0]            r_class_result, w_class_result;
  logic                  r_valid_in, w_valid_in;
  logic [DATA_WIDTH-1:0] r_pixel, w_pixel;

`ifdef CNN_STREAM_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1) + 1;
  logic [TO_W-1:0]       r_to_cnt, w_to_cnt;
  logic                  r_timeout_err, w_timeout_err;
`endif

  // Frame buffer: deliberately not reset so a frame survives a reset pulse
  logic [DATA_WIDTH-1:0] r_buf [IMG_PIXELS];
  logic                  w_wr_ok;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic [DATA_WIDTH-1:0] w_rd_data;

  // Host writes land only while idle and only inside the frame
  assign w_wr_ok = wr_en && (r_state == S_IDLE) &&
                   ({1'b0, wr_addr} < CNT_W'(IMG_PIXELS));

  // Read address: pixel 0 while idle (first pixel issued on start), else stream index
  always_comb begin
    w_rd_addr = {ADDR_WIDTH{1'b0}};
    if ((r_state == S_STREAM) && (r_pix_cnt < CNT_W'(IMG_PIXELS))) begin
      w_rd_addr = r_pix_cnt[ADDR_WIDTH-1:0];
    end else begin
      w_rd_addr = {ADDR_WIDTH{1'b0}};
    end
  end

  // A write coinciding with start must be the value streamed, so bypass the array
  assign w_rd_data = (w_wr_ok && (wr_addr == w_rd_addr)) ? wr_data : r_buf[w_rd_addr];

  // Frame buffer write port
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_buf[wr_addr] <= wr_data;
    end
  end

  // Next-state and next-output logic for the IDLE/STREAM/WAIT_RES/GAP sequence
  always_comb begin
    w_state        = r_state;
    w_pix_cnt      = r_pix_cnt;
    w_gap_cnt      = r_gap_cnt;
    w_busy         = r_busy;
    w_done         = 1'b0;
    w_class_valid  = 1'b0;
    w_class_result = r_class_result;
    w_valid_in     = 1'b0;
    w_pixel        = {DATA_WIDTH{1'b0}};
`ifdef CNN_STREAM_TIMEOUT_EN
    w_to_cnt       = r_to_cnt;
    w_timeout_err  = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state    = S_STREAM;
          w_busy     = 1'b1;
          w_valid_in = 1'b1;
          w_pixel    = w_rd_data;
          w_pix_cnt  = CNT_W'(1);
        end else begin
          w_busy     = 1'b0;
        end
      end
      S_STREAM: begin
        if (r_pix_cnt < CNT_W'(IMG_PIXELS)) begin
          w_valid_in = 1'b1;
          w_pixel    = w_rd_data;
          w_pix_cnt  = r_pix_cnt + CNT_W'(1);
        end else begin
          w_state    = S_WAIT_RES;
          w_pix_cnt  = {CNT_W{1'b0}};
`ifdef CNN_STREAM_TIMEOUT_EN
          w_to_cnt   = {TO_W{1'b0}};
`endif
        end
      end
      S_WAIT_RES: begin
        if (cnn_valid_out) begin
          w_class_result = cnn_class_out;
          w_class_valid  = 1'b1;
          w_state        = S_GAP;
          w_gap_cnt      = {GAP_W{1'b0}};
        end
`ifdef CNN_STREAM_TIMEOUT_EN
        else if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          w_timeout_err  = 1'b1;
          w_state        = S_GAP;
          w_gap_cnt      = {GAP_W{1'b0}};
        end else begin
          w_to_cnt       = r_to_cnt + TO_W'(1);
        end
`else
        else begin
          w_state        = S_WAIT_RES;
        end
`endif
      end
      S_GAP: begin
        if (r_gap_cnt == GAP_W'(GAP_CYCLES)) begin
          w_done    = 1'b1;
          w_busy    = 1'b0;
          w_state   = S_IDLE;
          w_gap_cnt = {GAP_W{1'b0}};
        end else begin
          w_gap_cnt = r_gap_cnt + GAP_W'(1);
        end
      end
      default: begin
        w_state = S_IDLE;
        w_busy  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset kills the stream asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_pix_cnt      <= {CNT_W{1'b0}};
      r_gap_cnt      <= {GAP_W{1'b0}};
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_class_valid  <= 1'b0;
      r_class_result <= 4'd0;
      r_valid_in     <= 1'b0;
      r_pixel        <= {DATA_WIDTH{1'b0}};
`ifdef CNN_STREAM_TIMEOUT_EN
      r_to_cnt       <= {TO_W{1'b0}};
      r_timeout_err  <= 1'b0;
`endif
    end else begin
      r_state        <= w_state;
      r_pix_cnt      <= w_pix_cnt;
      r_gap_cnt      <= w_gap_cnt;
      r_busy         <= w_busy;
      r_done         <= w_done;
      r_class_valid  <= w_class_valid;
      r_class_result <= w_class_result;
      r_valid_in     <= w_valid_in;
      r_pixel        <= w_pixel;
`ifdef CNN_STREAM_TIMEOUT_EN
      r_to_cnt       <= w_to_cnt;
      r_timeout_err  <= w_timeout_err;
`endif
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign class_valid  = r_class_valid;
  assign class_result = r_class_result;
  assign cnn_valid_in = r_valid_in;
  assign cnn_pixel_in = r_pixel;
`ifdef CNN_STREAM_TIMEOUT_EN
  assign timeout_err  = r_timeout_err;
`else
  assign timeout_err  = 1'b0;
`endif

endmodule

// File: tb/tb_cnn_frame_streamer.sv
// Randomized self-checking bench for cnn_frame_streamer. The reference is a
// plain array image of the frame buffer plus the last delivered class.
module tb_cnn_frame_streamer;
  localparam int DW   = 8;
  localparam int IW   = 28;
  localparam int AW   = 10;
  localparam int GAP  = 30;
  localparam int TO   = 100;
  localparam int NPIX = IW * IW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          start = 1'b0;
  logic          busy, done, class_valid, timeout_err, cnn_valid_in;
  logic [3:0]    class_result;
  logic [DW-1:0] cnn_pixel_in;
  logic          cnn_valid_out = 1'b0;
  logic [3:0]    cnn_class_out = 4'd0;

  int n_vec = 0;
  int n_err = 0;
  int mdl_buf [NPIX];
  int mdl_class = 0;

  always #5 clk = ~clk;

  cnn_frame_streamer #(
    .DATA_WIDTH(DW), .IMG_WIDTH(IW), .ADDR_WIDTH(AW),
    .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .busy(busy), .done(done), .class_valid(class_valid),
    .class_result(class_result), .timeout_err(timeout_err),
    .cnn_valid_in(cnn_valid_in), .cnn_pixel_in(cnn_pixel_in),
    .cnn_valid_out(cnn_valid_out), .cnn_class_out(cnn_class_out)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: digit-1 bar, mode 1: random pixels; ends with an out-of-frame write
  task automatic load_frame(input int mode);
    int v;
    for (int k = 0; k < NPIX; k++) begin
      if (mode == 0) v = ((k % IW) > 12 && (k % IW) < 16) ? 200 : 0;
      else           v = int'($urandom_range(0, 255));
      mdl_buf[k] = v;
      wr_en = 1'b1; wr_addr = AW'(k); wr_data = DW'(v);
      tick();
    end
    wr_en = 1'b1; wr_addr = AW'(NPIX + 3); wr_data = 8'hA5;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic run_frame(input bit wr_with_start, input bit disturb, input int abort_at,
                           input bit expect_to, input int cls, input int lat);
    int len, perr, n, spur, v;
    bit aborted;
    len = 0; perr = 0; spur = 0; aborted = 1'b0;
    if (wr_with_start) begin
      v = int'($urandom_range(1, 255));
      wr_en = 1'b1; wr_addr = AW'(0); wr_data = DW'(v);
      mdl_buf[0] = v;
    end
    start = 1'b1;
    tick();
    start = 1'b0; wr_en = 1'b0;
    chk("busy_start", busy, 1);
    chk("done_pulse", done, 0);
    for (int k = 0; k < NPIX; k++) begin
      if (cnn_valid_in === 1'b1) len++;
      if (cnn_pixel_in !== DW'(mdl_buf[k])) perr++;
      if (k == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk("abort_valid", cnn_valid_in, 0);
        chk("abort_busy", busy, 0);
        aborted = 1'b1;
        break;
      end
      if (disturb && k == 100) begin
        start = 1'b1;
        wr_en = 1'b1; wr_addr = AW'(k + 300); wr_data = ~DW'(mdl_buf[k + 300]);
        cnn_valid_out = 1'b1; cnn_class_out = 4'd3;
      end
      tick();
      start = 1'b0; wr_en = 1'b0; cnn_valid_out = 1'b0;
    end
    if (aborted) begin
      tick();
      tick();
      rst_n = 1'b1;
      mdl_class = 0;
      tick();
      chk("post_rst_busy", busy, 0);
      chk("post_rst_valid", cnn_valid_in, 0);
      chk("post_rst_class", class_result, 0);
      return;
    end
    chk("valid_len", len, NPIX);
    chk("pix_errs", perr, 0);
    chk("valid_end", cnn_valid_in, 0);
    chk("pixel_end", cnn_pixel_in, 0);
    chk("busy_wait", busy, 1);
    if (expect_to) begin
      n = 0;
      while (timeout_err !== 1'b1 && n < TO + 20) begin
        tick();
        n++;
        if (class_valid === 1'b1) spur++;
      end
      chk("to_cycles", n, TO);
      chk("to_class_kept", class_result, mdl_class);
    end else begin
      for (int i = 0; i < lat; i++) begin
        tick();
        if (class_valid === 1'b1 || timeout_err === 1'b1 || cnn_valid_in === 1'b1) spur++;
      end
      chk("class_kept", class_result, mdl_class);
      cnn_valid_out = 1'b1; cnn_class_out = 4'(cls);
      tick();
      cnn_valid_out = 1'b0;
      mdl_class = cls;
      chk("class_valid", class_valid, 1);
      chk("class_result", class_result, cls);
    end
    n = 0;
    while (done !== 1'b1 && n < GAP + 20) begin
      tick();
      n++;
      if (class_valid === 1'b1 || timeout_err === 1'b1) spur++;
    end
    chk("done_lat", n, GAP + 1);
    chk("busy_at_done", busy, 0);
    chk("class_at_done", class_result, mdl_class);
    chk("spurious", spur, 0);
  endtask

  initial begin
    int act;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cvalid", class_valid, 0);
    chk("rst_class", class_result, 0);
    chk("rst_to", timeout_err, 0);
    chk("rst_vin", cnn_valid_in, 0);
    chk("rst_pix", cnn_pixel_in, 0);
    rst_n = 1'b1;
    act = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cnn_valid_in !== 1'b0 || busy !== 1'b0) act++;
    end
    chk("idle_quiet", act, 0);

    load_frame(0);
    run_frame(1'b0, 1'b0, -1, 1'b0, 7, 50);
    run_frame(1'b0, 1'b1, -1, 1'b0, int'($urandom_range(0, 15)), int'($urandom_range(1, 80)));
    run_frame(1'b0, 1'b0, -1, 1'b0, int'($urandom_range(0, 15)), int'($urandom_range(0, 10)));
    load_frame(1);
    run_frame(1'b1, 1'b0, -1, 1'b0, int'($urandom_range(0, 15)), int'($urandom_range(0, 60)));
    run_frame(1'b0, 1'b0, 400, 1'b0, 0, 0);
    run_frame(1'b0, 1'b0, -1, 1'b0, int'($urandom_range(0, 15)), int'($urandom_range(0, 60)));
`ifdef CNN_STREAM_TIMEOUT_EN
    run_frame(1'b0, 1'b0, -1, 1'b1, 0, 0);
`endif
    for (int r = 0; r < 2; r++) begin
      run_frame(1'b1, r[0], -1, 1'b0, int'($urandom_range(0, 15)), int'($urandom_range(0, 40)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Watchdog so the run can never hang
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
